// File: rtl/serial_byte_queue.sv
// Serial-to-parallel byte receiver feeding a circular byte FIFO.
// Strobe inputs are rising-edge detected; data_out holds the last dequeued byte.
module serial_byte_queue #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clock_1MHz,
  input  logic             rst,
  input  logic             data_in,
  input  logic             write_in,
  input  logic             enqueue_in,
  input  logic             dequeue_in,
  output logic             status_out,
  output logic [WIDTH-1:0] data_out
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             write_prev_q, write_prev_d;
  logic             enq_prev_q, enq_prev_d;
  logic             deq_prev_q, deq_prev_d;
  logic             status_q, status_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             hold_q, hold_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic write_ev, enq_ev, deq_ev;
  logic full, empty;
  logic enq_ok, deq_ok;

  always_comb begin
    write_ev     = write_in & ~write_prev_q;
    enq_ev       = enqueue_in & ~enq_prev_q;
    deq_ev       = dequeue_in & ~deq_prev_q;
    full         = (count_q == CNT_W'(DEPTH));
    empty        = (count_q == CNT_W'(0));
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    deq_ok       = deq_ev & ~empty;
    enq_ok       = enq_ev & hold_q & (~full | deq_ok);

    write_prev_d = write_in;
    enq_prev_d   = enqueue_in;
    deq_prev_d   = dequeue_in;
    status_d     = ~hold_q & ~full;
    data_d       = data_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    hold_d       = hold_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;

    if (write_ev && status_q && !hold_q) begin
      shreg_d = {data_in, shreg_q[WIDTH-1:1]};
      if (bit_cnt_q == BIT_W'(WIDTH - 1)) begin
        bit_cnt_d = '0;
        hold_d    = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
      end
    end

    if (enq_ok) begin
      hold_d   = 1'b0;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    if (deq_ok) begin
      data_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    count_d = count_q + CNT_W'(enq_ok) - CNT_W'(deq_ok);
  end

  always_ff @(posedge clock_1MHz or posedge rst) begin
    if (rst) begin
      write_prev_q <= 1'b0;
      enq_prev_q   <= 1'b0;
      deq_prev_q   <= 1'b0;
      status_q     <= 1'b0;
      data_q       <= '0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      hold_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      write_prev_q <= write_prev_d;
      enq_prev_q   <= enq_prev_d;
      deq_prev_q   <= deq_prev_d;
      status_q     <= status_d;
      data_q       <= data_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      hold_q       <= hold_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Storage needs no reset: only entries counted by count_q are ever read.
  always_ff @(posedge clock_1MHz) begin
    if (enq_ok) begin
      mem_q[wr_ptr_q] <= shreg_q;
    end
  end

  assign status_out = status_q;
  assign data_out   = data_q;

endmodule

// File: tb/tb_serial_byte_queue.sv
// Directed bench for serial_byte_queue; a monitor checks data_out against a
// scoreboard of expected bytes after every dequeue strobe.
`timescale 1ns/1ps
module tb_serial_byte_queue;

  logic       clk;
  logic       rst;
  logic       data_in;
  logic       write_in;
  logic       enqueue_in;
  logic       dequeue_in;
  logic       status_out;
  logic [7:0] data_out;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [$];

  serial_byte_queue #(.WIDTH(8), .DEPTH(8)) dut (
    .clock_1MHz (clk),
    .rst        (rst),
    .data_in    (data_in),
    .write_in   (write_in),
    .enqueue_in (enqueue_in),
    .dequeue_in (dequeue_in),
    .status_out (status_out),
    .data_out   (data_out)
  );

  initial clk = 1'b0;
  always #500 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    data_in  = b;
    write_in = 1'b1;
    tick(10);
    write_in = 1'b0;
    tick(10);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic enq();
    enqueue_in = 1'b1;
    tick(2);
    enqueue_in = 1'b0;
    tick(3);
  endtask

  task automatic deq(input logic [7:0] e);
    sb.push_back(e);
    dequeue_in = 1'b1;
    tick(2);
    dequeue_in = 1'b0;
    tick(3);
  endtask

  task automatic enq_deq(input logic [7:0] e);
    sb.push_back(e);
    enqueue_in = 1'b1;
    dequeue_in = 1'b1;
    tick(2);
    enqueue_in = 1'b0;
    dequeue_in = 1'b0;
    tick(3);
  endtask

  // Monitor: a dequeue strobe seen at one negedge is registered by the next
  // posedge, so data_out is compared at the following negedge.
  initial begin
    logic mon_prev;
    logic pending;
    logic [7:0] exp;
    mon_prev = 1'b0;
    pending  = 1'b0;
    forever begin
      @(negedge clk);
      if (pending) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dequeue_unexpected: got 0x%0h, expected no dequeue", data_out);
        end else begin
          exp = sb.pop_front();
          chk("dequeue_data", 32'(data_out), 32'(exp));
        end
        pending = 1'b0;
      end
      if (!rst && dequeue_in && !mon_prev) pending = 1'b1;
      mon_prev = dequeue_in;
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL timeout: got no end of stimulus, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] v;
    rst        = 1'b1;
    data_in    = 1'b0;
    write_in   = 1'b0;
    enqueue_in = 1'b0;
    dequeue_in = 1'b0;

    // Reset and release
    tick(3);
    chk("reset_status", 32'(status_out), 32'd0);
    chk("reset_data", 32'(data_out), 32'h0);
    rst = 1'b0;
    chk("release_status_before_clk", 32'(status_out), 32'd0);
    tick(1);
    chk("release_status_after_clk", 32'(status_out), 32'd1);

    // Basic byte 0x99, LSB first
    v = 8'h99;
    for (int i = 0; i < 7; i++) send_bit(v[i]);
    chk("status_after_7_bits", 32'(status_out), 32'd1);
    send_bit(v[7]);
    chk("status_after_8_bits", 32'(status_out), 32'd0);
    enq();
    chk("status_after_enq", 32'(status_out), 32'd1);
    deq(8'h99);

    // Long write pulse counts once; extra edges while blocked are ignored
    v = 8'h35;
    data_in  = 1'b1;
    write_in = 1'b1;
    tick(50);
    write_in = 1'b0;
    tick(10);
    for (int i = 1; i < 8; i++) send_bit(v[i]);
    chk("status_long_pulse_byte", 32'(status_out), 32'd0);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("status_extra_edges", 32'(status_out), 32'd0);
    enq();
    deq(8'h35);

    // Fill to full, attempt more, then drain in order
    for (int k = 1; k <= 8; k++) begin
      send_byte(8'(k));
      enq();
      chk("fill_status", 32'(status_out), (k < 8) ? 32'd1 : 32'd0);
    end
    send_bit(1'b1);
    enq();
    chk("full_status_hold", 32'(status_out), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      deq(8'(k));
      if (k == 1) chk("status_after_first_drain", 32'(status_out), 32'd1);
    end

    // Empty dequeue and enqueue without a held byte (partial byte in shreg)
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    enq();
    deq(8'h08);
    chk("status_partial", 32'(status_out), 32'd1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);

    // Reset mid-operation with 3 bytes queued and 4 bits shifted
    send_byte(8'h11); enq();
    send_byte(8'h22); enq();
    send_byte(8'h33); enq();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    rst = 1'b1;
    tick(2);
    chk("midrst_status", 32'(status_out), 32'd0);
    chk("midrst_data", 32'(data_out), 32'h0);
    rst = 1'b0;
    tick(1);
    chk("midrst_release_status", 32'(status_out), 32'd1);
    send_byte(8'hA5);
    enq();
    deq(8'hA5);
    deq(8'hA5);

    // Simultaneous enqueue+dequeue, FIFO not empty
    send_byte(8'h3C);
    enq();
    send_byte(8'hC3);
    enq_deq(8'h3C);
    chk("status_after_simul", 32'(status_out), 32'd1);
    deq(8'hC3);

    // Simultaneous enqueue+dequeue, FIFO empty: pop ignored, push done
    send_byte(8'h5A);
    enq_deq(8'hC3);
    deq(8'h5A);

    tick(5);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
